// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int CACHE_DW   = 32;
  localparam int CACHE_SETS = 64;
  localparam int IDX_BITS   = $clog2(CACHE_SETS);
  localparam int TAG_BITS   = CACHE_DW - IDX_BITS - 2;

  typedef enum logic {IDLE, FILL} dcache_state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [IDX_BITS-1:0] idx;
  } addr_split_t;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [CACHE_DW-1:0] data;
    logic                set_valid;
  } line_wr_t;

  // Takes the word address (byte offset already stripped).
  function automatic addr_split_t split_addr(input logic [CACHE_DW-3:0] word_addr);
    addr_split_t s;
    s.tag = word_addr[CACHE_DW-3 -: TAG_BITS];
    s.idx = word_addr[IDX_BITS-1:0];
    return s;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays of the cache: combinational lookup, one write port.
module dcache_store
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [CACHE_DW-1:0] rd_data_o,
  input  logic                wr_en_i,
  input  line_wr_t            wr_i
);

  logic [CACHE_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0]   tag_q  [CACHE_SETS];
  logic [CACHE_DW-1:0]   data_q [CACHE_SETS];

  // Only the valid bits need reset; stale tag/data are masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_i.set_valid) begin
      valid_q[wr_i.idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_i.idx]  <= wr_i.tag;
      data_q[wr_i.idx] <= wr_i.data;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache with a one-entry
// write buffer, single-word refill FSM and hit/miss counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH  = CACHE_DW,
  parameter int SETS        = CACHE_SETS,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_re,
  input  logic                cpu_we,
  input  logic [CACHE_DW-1:0] cpu_addr,
  input  logic [CACHE_DW-1:0] cpu_wd,
  output logic [CACHE_DW-1:0] cpu_rd,
  output logic                stall,
  output logic [CACHE_DW-1:0] mem_raddr,
  input  logic [CACHE_DW-1:0] mem_rd,
  output logic [CACHE_DW-1:0] mem_waddr,
  output logic [CACHE_DW-1:0] mem_wd,
  output logic                mem_we,
  output logic [CACHE_DW-1:0] hit_cnt,
  output logic [CACHE_DW-1:0] miss_cnt
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY - 1);

  if (DATA_WIDTH != CACHE_DW || SETS != CACHE_SETS || MEM_LATENCY < 1) begin : g_bad_cfg
    $error("dcache_dm: unsupported DATA_WIDTH/SETS/MEM_LATENCY combination");
  end

  dcache_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CACHE_DW-3:0] fill_word_q, fill_word_d;
  logic                wb_valid_q;
  logic [CACHE_DW-3:0] wb_word_q;
  logic [CACHE_DW-1:0] wb_data_q;
  logic [CACHE_DW-1:0] hit_cnt_q, miss_cnt_q;

  logic [1:0]          unused_ofs;
  logic [CACHE_DW-3:0] req_word;
  addr_split_t         req, fill;
  logic                lk_valid, hit;
  logic [TAG_BITS-1:0] lk_tag;
  logic [CACHE_DW-1:0] lk_data;
  logic                wr_en, wb_load, hit_inc, miss_inc, stall_c;
  line_wr_t            wr;
  logic [CACHE_DW-1:0] rd_c;

  assign unused_ofs = cpu_addr[1:0];
  assign req_word   = cpu_addr[CACHE_DW-1:2];
  assign req        = split_addr(req_word);
  assign fill       = split_addr(fill_word_q);

  dcache_store u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (req.idx),
    .rd_valid_o(lk_valid),
    .rd_tag_o  (lk_tag),
    .rd_data_o (lk_data),
    .wr_en_i   (wr_en),
    .wr_i      (wr)
  );

  assign hit = lk_valid && (lk_tag == req.tag);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_word_d  = fill_word_q;
    stall_c      = 1'b0;
    rd_c         = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    wb_load      = 1'b0;
    wr_en        = 1'b0;
    wr.idx       = req.idx;
    wr.tag       = req.tag;
    wr.data      = cpu_wd;
    wr.set_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          wb_load = 1'b1;
          wr_en   = hit;
        end else if (cpu_re) begin
          if (hit) begin
            rd_c    = lk_data;
            hit_inc = 1'b1;
          end else begin
            stall_c     = 1'b1;
            miss_inc    = 1'b1;
            fill_word_d = req_word;
            cnt_d       = LAT_INIT;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          wr_en        = 1'b1;
          wr.idx       = fill.idx;
          wr.tag       = fill.tag;
          wr.data      = mem_rd;
          wr.set_valid = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_word_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_word_q   <= '0;
      wb_data_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_word_q <= fill_word_d;
      // The buffer drains every cycle, so a store is visible for exactly one cycle.
      wb_valid_q  <= wb_load;
      if (wb_load) begin
        wb_word_q <= req_word;
        wb_data_q <= cpu_wd;
      end
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Request inputs may be held during reset; keep the CPU-facing outputs quiet.
  assign stall     = rst_n & stall_c;
  assign cpu_rd    = rst_n ? rd_c : '0;
  assign mem_raddr = {fill_word_q, 2'b00};
  assign mem_we    = wb_valid_q;
  assign mem_waddr = {wb_word_q, 2'b00};
  assign mem_wd    = wb_data_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed loads/stores against a small RAM.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic [31:0] cpu_rd, mem_raddr, mem_rd, mem_waddr, mem_wd, hit_cnt, miss_cnt;
  logic        stall, mem_we;

  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] ram [1024];

  int n_checks = 0;
  int n_fail   = 0;
  int we_pairs = 0;
  logic [31:0] ld_q [$];
  logic [63:0] wr_q [$];

  always #5 clk = ~clk;

  dcache_dm #(.DATA_WIDTH(32), .SETS(64), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
    .mem_raddr(mem_raddr), .mem_rd(mem_rd), .mem_waddr(mem_waddr),
    .mem_wd(mem_wd), .mem_we(mem_we), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Two-port RAM: combinational read, synchronous write.
  assign mem_rd = ram[mem_raddr[11:2]];
  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (mem_we) ram[mem_waddr[11:2]] <= mem_wd;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents load data or a RAM write.
  initial begin
    logic        prev_we;
    logic [31:0] e;
    logic [63:0] w;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_re && !cpu_we && !stall) begin
        if (ld_q.size() == 0) check("unexpected load", cpu_rd, 32'hxxxx_xxxx);
        else begin
          e = ld_q.pop_front();
          check("load data", cpu_rd, e);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) check("unexpected mem_we", mem_waddr, 32'hxxxx_xxxx);
        else begin
          w = wr_q.pop_front();
          check("mem_waddr", mem_waddr, w[63:32]);
          check("mem_wd", mem_wd, w[31:0]);
        end
        if (prev_we) we_pairs++;
      end
      prev_we = mem_we;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_idx = a[11:2]; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_stalls, input string nm);
    int st;
    bit done;
    ld_q.push_back(exp_d);
    cpu_addr = a; cpu_re = 1'b1;
    st = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) st++;
      else done = 1'b1;
    end
    check({nm, " stall cycles"}, st, exp_stalls);
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    wr_q.push_back({a & 32'hFFFF_FFFC, d});
    cpu_addr = a; cpu_wd = d; cpu_we = 1'b1;
    @(negedge clk);
    check("store stall", stall, 32'd0);
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    preload(32'h0001_0000, 32'hDEAD_BEEF);
    preload(32'h0001_0004, 32'h1111_2222);
    preload(32'h0001_0100, 32'h0BAD_F00D);
    preload(32'h0001_0010, 32'h5555_6666);
    @(negedge clk);
    check("rst stall", stall, 0);
    check("rst cpu_rd", cpu_rd, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_waddr", mem_waddr, 0);
    check("rst mem_wd", mem_wd, 0);
    check("rst mem_raddr", mem_raddr, 0);
    check("rst hit_cnt", hit_cnt, 0);
    check("rst miss_cnt", miss_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(32'h0001_0000, 32'hDEAD_BEEF, 3, "first miss");
    check("hit after miss", hit_cnt, 1);
    check("miss after miss", miss_cnt, 1);
    check("fill raddr", mem_raddr, 32'h0001_0000);
    do_load(32'h0001_0000, 32'hDEAD_BEEF, 0, "repeat hit");
    check("hit after hit", hit_cnt, 2);

    do_load(32'h0001_0004, 32'h1111_2222, 3, "w1 miss");
    do_load(32'h0001_0004, 32'h1111_2222, 0, "w1 hit");
    do_store(32'h0001_0004, 32'h1234_5678);
    do_load(32'h0001_0004, 32'h1234_5678, 0, "store hit reload");
    check("hit cnt store hit", hit_cnt, 5);
    check("miss cnt store hit", miss_cnt, 2);

    do_store(32'h0001_0102, 32'hAAAA_5555);
    do_load(32'h0001_0100, 32'hAAAA_5555, 3, "no-alloc miss");
    check("miss cnt no-alloc", miss_cnt, 3);

    do_load(32'h0001_0000, 32'hDEAD_BEEF, 3, "conflict a");
    do_load(32'h0001_0100, 32'hAAAA_5555, 3, "conflict b");
    do_load(32'h0001_0000, 32'hDEAD_BEEF, 3, "conflict a again");
    check("hit cnt conflict", hit_cnt, 9);
    check("miss cnt conflict", miss_cnt, 6);

    check("no we pairs yet", we_pairs, 0);
    do_store(32'h0001_0008, 32'hCAFE_0001);
    do_store(32'h0001_000C, 32'hCAFE_0002);
    @(posedge clk); #1;
    check("back-to-back we pairs", we_pairs, 1);
    check("counters after stores", hit_cnt, 9);

    // Abort a fill with reset in its second FILL cycle.
    cpu_addr = 32'h0001_0010; cpu_re = 1'b1;
    @(negedge clk);
    check("abort detect stall", stall, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort stall", stall, 0);
    check("abort hit_cnt", hit_cnt, 0);
    check("abort miss_cnt", miss_cnt, 0);
    check("abort mem_raddr", mem_raddr, 0);
    check("abort mem_we", mem_we, 0);
    cpu_re = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(32'h0001_0010, 32'h5555_6666, 3, "post-abort miss");
    do_load(32'h0001_0000, 32'hDEAD_BEEF, 3, "post-reset miss");
    check("post-reset hit_cnt", hit_cnt, 2);
    check("post-reset miss_cnt", miss_cnt, 2);

    repeat (3) @(posedge clk);
    check("load queue drained", ld_q.size(), 0);
    check("write queue drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
